// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative signed
// multiply (shift-add) and signed restoring divide with a shared sign-fix state.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic               zero_q, zero_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic               pneg_q, pneg_d, rneg_q, rneg_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        alu_res = '0;
        case (alu_control)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_SUB: alu_res = a - b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR: alu_res = ~(a | b);
            OP_XOR: alu_res = a ^ b;
            OP_SLL: alu_res = b << shamt;
            OP_SRL: alu_res = b >> shamt;
            OP_SRA: alu_res = $signed(b) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Restoring step: remainder stays below the divisor, so WIDTH bits suffice after subtract.
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, dvs_q};
    assign div_sub   = div_shift[WIDTH-1:0] - dvs_q;
    assign prod_fix  = pneg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix   = pneg_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix   = rneg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        pneg_d   = pneg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    op_d  = alu_control;
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    if (alu_control == OP_MULT) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, mag(a)};
                        mplier_d = mag(b);
                        pneg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    end else if (alu_control == OP_DIV) begin
                        if (b == '0) begin
                            state_d = S_DONE;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d = S_DIV;
                            rem_d   = '0;
                            quo_d   = mag(a);
                            dvs_d   = mag(b);
                            pneg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                            rneg_d  = a[WIDTH-1];
                        end
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_DIV: begin
                rem_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (op_q == OP_MULT) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                result_d = lo_d;
                zero_d   = (lo_d == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            pneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            pneg_q   <= pneg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign done        = (state_q == S_DONE);
    assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_exec_unit;
    logic        clk = 0, reset = 1, start = 0;
    logic [3:0]  alu_control = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done, div_by_zero;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
        .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result", 64'(result), 64'(e.res));
                chk("zero", 64'(zero), 64'(e.z));
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] sh);
        start = 1; alu_control = op; a = va; b = vb; shamt = sh;
    endtask

    task automatic expect_done(input logic [31:0] r, input logic z, input logic [31:0] eh,
                               input logic [31:0] el, input logic d, input int at);
        exp_t e;
        e.res = r; e.z = z; e.hi = eh; e.lo = el; e.dbz = d; e.cyc = at;
        sb.push_back(e);
    endtask

    // One op: start for one cycle, then wait out its latency.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [4:0] sh, input logic [31:0] r, input logic z,
                         input logic [31:0] eh, input logic [31:0] el, input logic d,
                         input int lat);
        @(posedge clk); #1;
        drive(op, va, vb, sh);
        expect_done(r, z, eh, el, d, cyc + lat);
        @(posedge clk); #1;
        start = 0;
        repeat (lat) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_result"}, 64'(result), 64'd0);
        chk({tag, "_zero"}, 64'(zero), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'd0);
        chk({tag, "_lo"}, 64'(lo), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        check_all_zero("reset");

        issue(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b0110, 32'd5, 32'd5, 5'd0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b1010, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b0001, 32'h1, 32'h2, 5'd0, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b0100, 32'hFF, 32'h0F, 5'd0, 32'hF0, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b1100, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b1000, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b1001, 32'h0, 32'h80000000, 5'd31, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0, 1);
        issue(4'b1111, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1);

        // mult -3*7 with input changes and a stray start while busy
        @(posedge clk); #1;
        drive(4'b0101, 32'hFFFFFFFD, 32'd7, 5'd0);
        s = cyc;
        expect_done(32'hFFFFFFEB, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, s + 34);
        @(posedge clk); #1;
        start = 0; a = 0; b = 0;
        chk("mul_busy_c1", 64'(busy), 64'd1);
        @(posedge clk); #1;
        drive(4'b0010, 32'd1, 32'd1, 5'd0);
        @(posedge clk); #1;
        start = 0;
        while (cyc < s + 33) begin @(posedge clk); #1; end
        chk("mul_busy_c33", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("mul_busy_c34", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);

        issue(4'b0101, 32'h00010000, 32'h00010000, 5'd0, 32'h0, 1'b1, 32'h1, 32'h0, 1'b0, 34);
        issue(4'b1011, 32'hFFFFFFF9, 32'd2, 5'd0, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
        issue(4'b1011, 32'd5, 32'd0, 5'd0, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1);
        issue(4'b0010, 32'd1, 32'd1, 5'd0, 32'h2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1);
        issue(4'b1011, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b0, 32'h0, 32'h80000000, 1'b0, 34);

        // reset in cycle 10 of a div: abort, no done pulse afterwards
        @(posedge clk); #1;
        drive(4'b1011, 32'd100, 32'd7, 5'd0);
        s = cyc;
        @(posedge clk); #1;
        start = 0;
        while (cyc < s + 10) begin @(posedge clk); #1; end
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check_all_zero("abort");
        repeat (40) @(posedge clk);

        // back-to-back: second start in the DONE cycle of the first
        @(posedge clk); #1;
        drive(4'b0010, 32'd2, 32'd3, 5'd0);
        s = cyc;
        expect_done(32'd5, 1'b0, 32'h0, 32'h0, 1'b0, s + 1);
        @(posedge clk); #1;
        drive(4'b0110, 32'd10, 32'd3, 5'd0);
        expect_done(32'd7, 1'b0, 32'h0, 32'h0, 1'b0, s + 2);
        @(posedge clk); #1;
        start = 0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) chk("pending_completions", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
